// File: rtl/darkriscv_mem_arbiter.sv
// darkriscv_mem_arbiter
//   Connects the darkriscv core's separate instruction and data buses to a
//   single-ported memory that uses a req/ack handshake. Each core step runs
//   in a fixed order: first the pending data access (if any), then the
//   instruction fetch (unless the one-entry fetch tag already holds IADDR).
//   After that the core is released (HLT=0) for exactly one cycle. A
//   watchdog aborts any memory access that waits too long for MACK and sets
//   the sticky ERR flag.
//
// Parameters
//   TIMEOUT  max wait cycles in one access before it is aborted (0 = off)
//   ERRDATA  word returned for an aborted read or fetch (RV32I NOP)
//
// Ports
//   CLK, RES         clock (rising edge), asynchronous active-high reset
//   IADDR / IDATA    core fetch address / registered fetched instruction
//   DADDR, DATAO, BE core data address, store data, byte enables
//   WR, RD           core store / load request
//   DATAI            registered load data
//   HLT              core stall; the core advances only on edges with HLT=0
//   MREQ, MWE, MADDR, MBE, MWDATA   memory request side
//   MACK, MRDATA     memory acknowledge and read data
//   ERR              sticky watchdog-abort flag
module darkriscv_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] ERRDATA = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] IADDR,
    output logic [31:0] IDATA,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    output logic [31:0] DATAI,
    input  logic [3:0]  BE,
    input  logic        WR,
    input  logic        RD,
    output logic        HLT,
    output logic        MREQ,
    output logic        MWE,
    output logic [31:0] MADDR,
    output logic [3:0]  MBE,
    output logic [31:0] MWDATA,
    input  logic        MACK,
    input  logic [31:0] MRDATA,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA    = 2'd1,
        S_FETCH   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Counter just wide enough to hold TIMEOUT; it saturates there.
    localparam int unsigned    WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [31:0]      idata_q, idata_d;
    logic [31:0]      datai_q, datai_d;
    logic [31:0]      tag_q, tag_d;
    logic             tag_valid_q, tag_valid_d;
    logic             err_q, err_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             hlt_q, hlt_d;
    logic             mreq_q, mreq_d;
    logic             mwe_q, mwe_d;

    logic             need_fetch;
    logic             in_access;
    logic             wd_expired;
    logic             step_done;
    logic             wr_hits_tag;
    logic [31:0]      rdata;

    always_comb begin
        need_fetch  = !tag_valid_q || (IADDR != tag_q);
        in_access   = (state_q == S_DATA) || (state_q == S_FETCH);
        // A real MACK on the expiry cycle still wins over the abort.
        wd_expired  = (TIMEOUT != 0) && in_access && !MACK && (wdog_q == WD_MAX);
        step_done   = MACK || wd_expired;
        // Stores into the word currently held as instruction must force a
        // re-fetch (self-modifying code).
        wr_hits_tag = WR && tag_valid_q && (DADDR[31:2] == tag_q[31:2]);
        rdata       = wd_expired ? ERRDATA : MRDATA;
    end

    always_comb begin
        state_d     = state_q;
        idata_d     = idata_q;
        datai_d     = datai_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (RD || WR)
                    state_d = S_DATA;
                else if (need_fetch)
                    state_d = S_FETCH;
                else
                    state_d = S_RELEASE;
            end
            S_DATA: begin
                if (step_done) begin
                    if (!WR)
                        datai_d = rdata;
                    if (wr_hits_tag)
                        tag_valid_d = 1'b0;
                    if (wd_expired)
                        err_d = 1'b1;
                    state_d = (wr_hits_tag || need_fetch) ? S_FETCH : S_RELEASE;
                end
            end
            S_FETCH: begin
                if (step_done) begin
                    idata_d     = rdata;
                    tag_d       = IADDR;
                    // An aborted fetch must not be trusted as a tag hit.
                    tag_valid_d = !wd_expired;
                    if (wd_expired)
                        err_d = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Watchdog restarts on every state change and never wraps.
        if (state_d != state_q)
            wdog_d = '0;
        else if (in_access && !MACK && (wdog_q != WD_MAX))
            wdog_d = wdog_q + WD_W'(1);
        else
            wdog_d = wdog_q;

        // Control outputs are registered as a decode of the next state.
        hlt_d  = (state_d != S_RELEASE);
        mreq_d = (state_d == S_DATA) || (state_d == S_FETCH);
        mwe_d  = (state_d == S_DATA) && WR;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q     <= S_IDLE;
            idata_q     <= '0;
            datai_q     <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
            hlt_q       <= 1'b1;
            mreq_q      <= 1'b0;
            mwe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idata_q     <= idata_d;
            datai_q     <= datai_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
            hlt_q       <= hlt_d;
            mreq_q      <= mreq_d;
            mwe_q       <= mwe_d;
        end
    end

    // Address/data path: the core holds these inputs stable while HLT=1.
    assign MADDR  = (state_q == S_DATA) ? DADDR : IADDR;
    assign MBE    = (state_q == S_DATA) ? BE : 4'hF;
    assign MWDATA = DATAO;

    assign HLT   = hlt_q;
    assign MREQ  = mreq_q;
    assign MWE   = mwe_q;
    assign IDATA = idata_q;
    assign DATAI = datai_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_darkriscv_mem_arbiter.sv
module tb_darkriscv_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic [31:0] IADDR = '0;
    logic [31:0] IDATA;
    logic [31:0] DADDR = '0;
    logic [31:0] DATAO = '0;
    logic [31:0] DATAI;
    logic [3:0]  BE = 4'hF;
    logic        WR = 1'b0;
    logic        RD = 1'b0;
    logic        HLT;
    logic        MREQ;
    logic        MWE;
    logic [31:0] MADDR;
    logic [3:0]  MBE;
    logic [31:0] MWDATA;
    logic        MACK;
    logic [31:0] MRDATA;
    logic        ERR;

    int errors = 0;
    int checks = 0;

    // Memory model: data accesses wait dwait cycles, fetches fwait cycles.
    logic [31:0] mem [0:255];
    int          dwait = 0;
    int          fwait = 0;
    logic        mem_hang = 1'b0;
    int          mcnt = 0;
    int          cur_wait;

    darkriscv_mem_arbiter #(.TIMEOUT(4), .ERRDATA(32'h00000013)) dut (
        .CLK(CLK), .RES(RES), .IADDR(IADDR), .IDATA(IDATA), .DADDR(DADDR),
        .DATAO(DATAO), .DATAI(DATAI), .BE(BE), .WR(WR), .RD(RD), .HLT(HLT),
        .MREQ(MREQ), .MWE(MWE), .MADDR(MADDR), .MBE(MBE), .MWDATA(MWDATA),
        .MACK(MACK), .MRDATA(MRDATA), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    assign cur_wait = ((RD || WR) && (MADDR == DADDR)) ? dwait : fwait;
    assign MACK     = MREQ && !mem_hang && (mcnt == cur_wait);
    assign MRDATA   = mem[MADDR[9:2]];

    always @(posedge CLK) begin
        if (!MREQ || MACK) mcnt <= 0;
        else               mcnt <= mcnt + 1;
    end

    always @(posedge CLK) begin
        if (RES) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h00000093;
            mem[1]  <= 32'h00100113;
            mem[2]  <= 32'h00200193;
            mem[3]  <= 32'h00300213;
            mem[64] <= 32'hDEADBEEF;
        end else if (MREQ && MACK && MWE) begin
            for (int b = 0; b < 4; b++)
                if (MBE[b]) mem[MADDR[9:2]][8*b +: 8] <= MWDATA[8*b +: 8];
        end
    end

    // Results of the most recent pass (IDLE through the HLT=0 cycle).
    int          p_lat;
    int          p_nreq;
    logic [31:0] p_addr0, p_addrn, p_wd0;
    logic        p_we0;
    logic [3:0]  p_be0;

    // Must be called at the negedge of an IDLE cycle; returns at the
    // negedge of the release cycle.
    task automatic do_pass(input string name);
        bit done = 0;
        p_lat = 0; p_nreq = 0;
        p_addr0 = '0; p_addrn = '0; p_wd0 = '0; p_we0 = 1'b0; p_be0 = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            p_lat++;
            if (MREQ) begin
                if (p_nreq == 0) begin
                    p_addr0 = MADDR; p_we0 = MWE; p_be0 = MBE; p_wd0 = MWDATA;
                end
                p_addrn = MADDR;
                p_nreq++;
            end
            if (!HLT) done = 1;
            else @(negedge CLK);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_release got no release want release within 40 cycles", name);
        end
        $display("pass %s: lat=%0d nreq=%0d addr0=%h we0=%b be0=%h addrn=%h IDATA=%h DATAI=%h ERR=%b",
                 name, p_lat, p_nreq, p_addr0, p_we0, p_be0, p_addrn, IDATA, DATAI, ERR);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if (HLT !== 1'b1) begin errors++; $display("FAIL rst_hlt got %b want 1", HLT); end
        checks++; if (MREQ !== 1'b0) begin errors++; $display("FAIL rst_mreq got %b want 0", MREQ); end
        checks++; if (MWE !== 1'b0) begin errors++; $display("FAIL rst_mwe got %b want 0", MWE); end
        checks++; if (IDATA !== 32'h0) begin errors++; $display("FAIL rst_idata got %h want 0", IDATA); end
        checks++; if (DATAI !== 32'h0) begin errors++; $display("FAIL rst_datai got %h want 0", DATAI); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", ERR); end
        RES = 1'b0;
    endtask

    task automatic test_cold_fetch();
        do_pass("cold_fetch");
        checks++; if (p_lat != 3) begin errors++; $display("FAIL t1_lat got %0d want 3", p_lat); end
        checks++; if (p_nreq != 1) begin errors++; $display("FAIL t1_nreq got %0d want 1", p_nreq); end
        checks++; if (p_addr0 !== 32'h0) begin errors++; $display("FAIL t1_maddr got %h want 0", p_addr0); end
        checks++; if (p_we0 !== 1'b0) begin errors++; $display("FAIL t1_mwe got %b want 0", p_we0); end
        checks++; if (p_be0 !== 4'hF) begin errors++; $display("FAIL t1_mbe got %h want f", p_be0); end
        checks++; if (IDATA !== 32'h00000093) begin errors++; $display("FAIL t1_idata got %h want 00000093", IDATA); end
    endtask

    task automatic test_tag_hit();
        IADDR = 32'h4;
        @(negedge CLK);
        checks++; if (HLT !== 1'b1) begin errors++; $display("FAIL t2_pulse got %b want 1", HLT); end
        do_pass("seq_miss");
        checks++; if (p_lat != 3) begin errors++; $display("FAIL t2_miss_lat got %0d want 3", p_lat); end
        checks++; if (IDATA !== 32'h00100113) begin errors++; $display("FAIL t2_miss_idata got %h want 00100113", IDATA); end
        @(negedge CLK);
        do_pass("tag_hit");
        checks++; if (p_lat != 2) begin errors++; $display("FAIL t2_hit_lat got %0d want 2", p_lat); end
        checks++; if (p_nreq != 0) begin errors++; $display("FAIL t2_hit_nreq got %0d want 0", p_nreq); end
        checks++; if (IDATA !== 32'h00100113) begin errors++; $display("FAIL t2_hit_idata got %h want 00100113", IDATA); end
    endtask

    task automatic test_load_then_fetch();
        RD = 1'b1; DADDR = 32'h100; BE = 4'hF; IADDR = 32'h8; dwait = 3; fwait = 0;
        @(negedge CLK);
        do_pass("load_fetch");
        checks++; if (p_lat != 7) begin errors++; $display("FAIL t3_lat got %0d want 7", p_lat); end
        checks++; if (p_nreq != 5) begin errors++; $display("FAIL t3_nreq got %0d want 5", p_nreq); end
        checks++; if (p_addr0 !== 32'h100) begin errors++; $display("FAIL t3_daddr got %h want 00000100", p_addr0); end
        checks++; if (p_we0 !== 1'b0) begin errors++; $display("FAIL t3_mwe got %b want 0", p_we0); end
        checks++; if (p_addrn !== 32'h8) begin errors++; $display("FAIL t3_faddr got %h want 00000008", p_addrn); end
        checks++; if (DATAI !== 32'hDEADBEEF) begin errors++; $display("FAIL t3_datai got %h want deadbeef", DATAI); end
        checks++; if (IDATA !== 32'h00200193) begin errors++; $display("FAIL t3_idata got %h want 00200193", IDATA); end
        RD = 1'b0; dwait = 0;
    endtask

    task automatic test_store_invalidate();
        IADDR = 32'h4;
        @(negedge CLK);
        do_pass("refill_tag");
        checks++; if (p_lat != 3) begin errors++; $display("FAIL t4_pre_lat got %0d want 3", p_lat); end
        WR = 1'b1; RD = 1'b1; DADDR = 32'h4; DATAO = 32'h12345678; BE = 4'h3;
        @(negedge CLK);
        do_pass("store_inval");
        checks++; if (p_lat != 4) begin errors++; $display("FAIL t4_lat got %0d want 4", p_lat); end
        checks++; if (p_nreq != 2) begin errors++; $display("FAIL t4_nreq got %0d want 2", p_nreq); end
        checks++; if (p_we0 !== 1'b1) begin errors++; $display("FAIL t4_mwe got %b want 1", p_we0); end
        checks++; if (p_be0 !== 4'h3) begin errors++; $display("FAIL t4_mbe got %h want 3", p_be0); end
        checks++; if (p_wd0 !== 32'h12345678) begin errors++; $display("FAIL t4_mwdata got %h want 12345678", p_wd0); end
        checks++; if (IDATA !== 32'h00105678) begin errors++; $display("FAIL t4_idata got %h want 00105678", IDATA); end
        checks++; if (DATAI !== 32'hDEADBEEF) begin errors++; $display("FAIL t4_datai got %h want deadbeef", DATAI); end
        WR = 1'b0; RD = 1'b0; BE = 4'hF;
    endtask

    task automatic test_watchdog();
        IADDR = 32'hC; mem_hang = 1'b1;
        @(negedge CLK);
        do_pass("fetch_abort");
        checks++; if (p_lat != 7) begin errors++; $display("FAIL t5_lat got %0d want 7", p_lat); end
        checks++; if (IDATA !== 32'h00000013) begin errors++; $display("FAIL t5_idata got %h want 00000013", IDATA); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL t5_err got %b want 1", ERR); end
        mem_hang = 1'b0;
        @(negedge CLK);
        do_pass("refetch");
        checks++; if (p_nreq != 1) begin errors++; $display("FAIL t5_refetch_nreq got %0d want 1", p_nreq); end
        checks++; if (IDATA !== 32'h00300213) begin errors++; $display("FAIL t5_refetch_idata got %h want 00300213", IDATA); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL t5_err_sticky got %b want 1", ERR); end
    endtask

    task automatic test_async_reset();
        RD = 1'b1; DADDR = 32'h100; dwait = 3;
        @(negedge CLK);          // IDLE
        @(negedge CLK);          // first DATA cycle
        checks++; if (MREQ !== 1'b1) begin errors++; $display("FAIL t6_mreq_pre got %b want 1", MREQ); end
        #2 RES = 1'b1;
        #1;
        checks++; if (MREQ !== 1'b0) begin errors++; $display("FAIL t6_mreq got %b want 0", MREQ); end
        checks++; if (HLT !== 1'b1) begin errors++; $display("FAIL t6_hlt got %b want 1", HLT); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL t6_err got %b want 0", ERR); end
        checks++; if (IDATA !== 32'h0) begin errors++; $display("FAIL t6_idata got %h want 0", IDATA); end
        checks++; if (DATAI !== 32'h0) begin errors++; $display("FAIL t6_datai got %h want 0", DATAI); end
        $display("async reset asserted mid-access: MREQ=%b HLT=%b ERR=%b", MREQ, HLT, ERR);
        RD = 1'b0; dwait = 0;
        @(negedge CLK);
        RES = 1'b0;
        do_pass("post_reset");
        checks++; if (p_lat != 3) begin errors++; $display("FAIL t6_lat got %0d want 3", p_lat); end
        checks++; if (p_nreq != 1) begin errors++; $display("FAIL t6_nreq got %0d want 1", p_nreq); end
        checks++; if (IDATA !== 32'h00300213) begin errors++; $display("FAIL t6_idata_post got %h want 00300213", IDATA); end
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_tag_hit();
        test_load_then_fetch();
        test_store_invalidate();
        test_watchdog();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
